// File: rtl/mem_write_buffer.sv
// mem_write_buffer: write-back FIFO between the D-cache and slow memory with coalescing, read forwarding and read bypass
module mem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 28
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c_read,
    input  logic          c_write,
    input  logic [AW-1:0] c_addr,
    input  logic [127:0]  c_wdata,
    output logic [127:0]  c_rdata,
    output logic          c_ready,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [127:0]  mem_wdata,
    input  logic [127:0]  mem_rdata,
    input  logic          mem_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;
    logic [AW-1:0]   addr_q [DEPTH];
    logic [127:0]    data_q [DEPTH];
    logic            c_ready_q;
    logic [127:0]    c_rdata_q;
    logic            hit;
    logic [PW-1:0]   hit_idx;
    logic            full, wr_acc, push, pop, fwd, rd_miss;

    // address match against the live entries between head and head+count
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PW'(i) - head_q} < count_q && addr_q[PW'(i)] == c_addr) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    // a coalescing write onto the entry currently being drained waits so mem_wdata stays stable
    assign full    = count_q == CW'(DEPTH);
    assign wr_acc  = c_write && !c_ready_q && (hit ? !(state_q == DRAIN && hit_idx == head_q) : !full);
    assign push    = wr_acc && !hit;
    assign pop     = state_q == DRAIN && mem_ready;
    assign fwd     = c_read && !c_write && !c_ready_q && hit;
    assign rd_miss = c_read && !c_write && !c_ready_q && !hit;

    // next state: read misses bypass queued drains, but never interrupt one in flight
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = rd_miss ? READ : (count_q != '0 ? DRAIN : IDLE);
            DRAIN:   state_d = mem_ready ? IDLE : DRAIN;
            READ:    state_d = mem_ready ? RESP : READ;
            default: state_d = IDLE;
        endcase
    end

    assign mem_write = state_q == DRAIN;
    assign mem_read  = state_q == READ;
    assign mem_addr  = state_q == DRAIN ? addr_q[head_q] : (state_q == READ ? c_addr : '0);
    assign mem_wdata = state_q == DRAIN ? data_q[head_q] : '0;
    assign c_ready   = c_ready_q;
    assign c_rdata   = c_rdata_q;

    // control state, pointers, count and cache response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            c_ready_q <= 1'b0;
            c_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_q + PW'(pop);
            tail_q    <= tail_q + PW'(push);
            count_q   <= count_q + CW'(push) - CW'(pop);
            c_ready_q <= wr_acc || fwd || (state_q == READ && mem_ready);
            if (fwd)
                c_rdata_q <= data_q[hit_idx];
            else if (state_q == READ && mem_ready)
                c_rdata_q <= mem_rdata;
        end
    end

    // entry storage: a hit overwrites in place, otherwise the write lands at the tail
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            addr_q[hit ? hit_idx : tail_q] <= c_addr;
            data_q[hit ? hit_idx : tail_q] <= c_wdata;
        end
    end
endmodule

// File: tb/tb_mem_write_buffer.sv
// tb_mem_write_buffer: scoreboard bench for mem_write_buffer with a latency-programmable slow memory
module tb_mem_write_buffer;
    localparam int AW = 28;

    typedef struct {
        logic [AW-1:0] a;
        logic [127:0]  d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          c_read = 1'b0;
    logic          c_write = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [127:0]  c_wdata = '0;
    logic [127:0]  c_rdata;
    logic          c_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata = '0;
    logic          mem_ready = 1'b0;

    int            n_chk = 0;
    int            n_err = 0;
    ent_t          mq[$];
    byte           tlog[$];
    int            lat = 3;
    bit            stall = 1'b0;
    int            rd_starts = 0;
    int            wr_starts = 0;
    longint        last_drain_t = 0;

    always #5 clk = ~clk;

    mem_write_buffer #(.DEPTH(4), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .c_read(c_read), .c_write(c_write), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ready(c_ready), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pat(input logic [AW-1:0] a);
        return {4{4'hD, a}};
    endfunction

    function automatic logic [127:0] model_get(input logic [AW-1:0] a);
        logic [127:0] d = pat(a);
        foreach (mq[i]) if (mq[i].a == a) d = mq[i].d;
        return d;
    endfunction

    // slow memory: answers after lat cycles of a held request; checks drains against the scoreboard
    task automatic mem_model();
        logic [AW-1:0] sa;
        logic [127:0]  sd;
        int            cnt = 0;
        ent_t          e;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                mem_ready = 1'b0;
                cnt = 0;
            end else if (mem_read || mem_write) begin
                if (mem_read && mem_write) chk("rw_excl", {mem_read, mem_write}, 2'b01);
                if (cnt == 0) begin
                    sa = mem_addr;
                    sd = mem_wdata;
                    if (mem_read) rd_starts++;
                    else wr_starts++;
                    tlog.push_back(mem_read ? 8'h52 : 8'h57);
                end
                cnt++;
                if (!stall && cnt >= lat) begin
                    chk("addr_stable", 128'(mem_addr), 128'(sa));
                    mem_ready = 1'b1;
                    mem_rdata = pat(mem_addr);
                    if (mem_write) begin
                        chk("wdata_stable", mem_wdata, sd);
                        last_drain_t = longint'($time);
                        if (mq.size() == 0) chk("drain_unexpected", 128'(mem_addr), 128'h0);
                        else begin
                            e = mq.pop_front();
                            chk("drain_addr", 128'(mem_addr), 128'(e.a));
                            chk("drain_data", mem_wdata, e.d);
                        end
                    end
                end
            end else cnt = 0;
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [127:0] d, output int cyc);
        bit found = 1'b0;
        @(negedge clk);
        c_write = 1'b1;
        c_addr  = a;
        c_wdata = d;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!c_ready && cyc < 300);
        if (!c_ready) chk("wr_timeout", 128'(c_ready), 128'h1);
        else begin
            foreach (mq[i]) if (mq[i].a == a) begin
                mq[i].d = d;
                found = 1'b1;
            end
            if (!found) mq.push_back('{a, d});
        end
        c_write = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [127:0] exp, output int cyc);
        @(negedge clk);
        c_read = 1'b1;
        c_addr = a;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!c_ready && cyc < 300);
        if (!c_ready) chk("rd_timeout", 128'(c_ready), 128'h1);
        else chk("rd_data", c_rdata, exp);
        c_read = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((mq.size() != 0 || mem_write || mem_read || mem_ready) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        chk("drain_done", 128'(k < 1000), 128'h1);
        chk("count_zero", 128'(dut.count_q), 128'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, n, w, r, k;
        fork
            mem_model();
        join_none
        repeat (3) @(negedge clk);
        chk("rst_c_ready", 128'(c_ready), 128'h0);
        chk("rst_mem_rw", 128'({mem_read, mem_write}), 128'h0);
        chk("rst_mem_addr", 128'(mem_addr), 128'h0);
        chk("rst_mem_wdata", mem_wdata, 128'h0);
        chk("rst_c_rdata", c_rdata, 128'h0);
        chk("rst_count", 128'(dut.count_q), 128'h0);
        rst_n = 1'b1;

        // single write drains to memory
        lat = 3;
        do_write(28'h0000010, 128'hAAAA_0000_1111_2222_3333_4444_5555_6666, cyc);
        chk("single_wr_lat", 128'(cyc), 128'h1);
        wait_idle();

        // read-after-write forwarding while memory is stalled
        stall = 1'b1;
        do_write(28'h20, 128'hBBBB_BBBB_0000_0000_1234_5678_9ABC_DEF0, cyc);
        r = rd_starts;
        do_read(28'h20, model_get(28'h20), cyc);
        chk("fwd_lat", 128'(cyc), 128'h1);
        chk("fwd_no_mem_read", 128'(rd_starts), 128'(r));
        stall = 1'b0;
        wait_idle();

        // full buffer stalls the fifth write until the first drain frees an entry
        lat = 10;
        for (int i = 0; i < 4; i++) begin
            do_write(28'h100 + 28'(i), pat(28'h700 + 28'(i)), cyc);
            chk("fill_wr_lat", 128'(cyc), 128'h1);
        end
        do_write(28'h104, pat(28'h704), cyc);
        chk("full_wr_stalled", 128'(cyc > 1), 128'h1);
        chk("full_wr_after_drain", 128'((longint'($time) - last_drain_t) / 10), 128'h2);
        wait_idle();

        // coalescing into a full buffer is immediate and keeps count at 4
        lat = 3;
        stall = 1'b1;
        for (int i = 1; i <= 4; i++) do_write(28'(i), pat(28'h800 + 28'(i)), cyc);
        do_write(28'h2, 128'hCCCC_CCCC_CCCC_CCCC_0000_0000_0000_0002, cyc);
        chk("coal_full_lat", 128'(cyc), 128'h1);
        chk("coal_full_count", 128'(dut.count_q), 128'h4);
        stall = 1'b0;
        wait_idle();

        // a write onto the head entry in flight waits for the drain
        stall = 1'b1;
        do_write(28'h30, 128'hD1, cyc);
        fork
            do_write(28'h30, 128'hD2, cyc);
            begin
                repeat (6) @(negedge clk);
                stall = 1'b0;
            end
        join
        chk("head_coal_stalled", 128'(cyc >= 6), 128'h1);
        wait_idle();

        // read miss bypasses queued drains once the active drain ends
        stall = 1'b1;
        for (int i = 0; i < 3; i++) do_write(28'h40 + 28'(i), pat(28'h900 + 28'(i)), cyc);
        n = tlog.size();
        fork
            do_read(28'h99, pat(28'h99), cyc);
            begin
                repeat (4) @(negedge clk);
                stall = 1'b0;
            end
        join
        if (tlog.size() > n) chk("bypass_first_read", 128'(tlog[n]), 128'h52);
        else chk("bypass_no_txn", 128'(tlog.size()), 128'(n + 1));
        wait_idle();

        // reset in the middle of a drain aborts it and discards the buffer
        stall = 1'b1;
        do_write(28'h60, 128'hE0, cyc);
        k = 0;
        while (!mem_write && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_started", 128'(mem_write), 128'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_write", 128'(mem_write), 128'h0);
        chk("rst_mid_count", 128'(dut.count_q), 128'h0);
        mq.delete();
        stall = 1'b0;
        w = wr_starts;
        r = rd_starts;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_no_new_write", 128'(wr_starts), 128'(w));
        chk("rst_no_new_read", 128'(rd_starts), 128'(r));
        chk("rst_after_count", 128'(dut.count_q), 128'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
